// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MEM-stage load/store initiator. It checks alignment, builds the
// word address, byte enables and lane-replicated store data, and runs a
// req/ack access to data memory. Load results are extracted and extended.
module lsu_ctrl #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  stall,
    output logic                  mem_fault,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_is_load;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic                  r_we;
    logic [DM_ADDRESS-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_rd;

    logic                  w_req_in;
    logic                  w_f3_legal;
    logic                  w_misaligned;
    logic                  w_fault;
    logic [3:0]            w_be;
    logic [DATA_W-1:0]     w_wdata;
    logic [DATA_W-1:0]     w_shifted;
    logic [DATA_W-1:0]     w_load_data;

    assign w_req_in = MemRead | MemWrite;

    // Request decode: legality of Funct3 for the winning op and alignment.
    always_comb begin
        w_f3_legal = 1'b0;
        if (MemRead) begin
            case (Funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_legal = 1'b1;
                default:                                w_f3_legal = 1'b0;
            endcase
        end else begin
            case (Funct3)
                3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
                default:                w_f3_legal = 1'b0;
            endcase
        end
        w_misaligned = 1'b0;
        case (Funct3[1:0])
            2'b01:   w_misaligned = addr[0];
            2'b10:   w_misaligned = |addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
        w_fault = ~w_f3_legal | w_misaligned;
    end

    // Store lane steering; loads always read the full word.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wd;
        if (!MemRead) begin
            case (Funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << addr[1:0];
                    w_wdata = {4{wd[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << addr[1:0];
                    w_wdata = {2{wd[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wd;
                end
            endcase
        end
    end

    // Load extraction from the returned word using the latched offset.
    always_comb begin
        w_shifted   = mem_rdata >> {r_off, 3'b000};
        w_load_data = w_shifted;
        case (r_f3)
            3'b000:  w_load_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_load_data = {{(DATA_W-8){1'b0}}, w_shifted[7:0]};
            3'b101:  w_load_data = {{(DATA_W-16){1'b0}}, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; DONE and ERR always return to IDLE so held requests
    // from the completed instruction cannot re-trigger.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_req_in) w_state_next = w_fault ? ERR : BUSY;
            BUSY: if (mem_ack)  w_state_next = DONE;
            DONE: w_state_next = IDLE;
            ERR:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Access latch on acceptance and load result capture on ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_load <= 1'b0;
            r_f3      <= '0;
            r_off     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
        end else begin
            if (r_state == IDLE && w_req_in) begin
                r_is_load <= MemRead;
                r_f3      <= Funct3;
                r_off     <= addr[1:0];
                r_we      <= ~MemRead;
                r_addr    <= {addr[DM_ADDRESS-1:2], 2'b00};
                r_be      <= w_be;
                r_wdata   <= w_wdata;
            end
            if (r_state == BUSY && mem_ack && r_is_load) begin
                r_rd <= w_load_data;
            end
        end
    end

    assign mem_req   = (r_state == BUSY);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_be    = r_be;
    assign mem_wdata = r_wdata;
    assign rd        = r_rd;
    assign rd_valid  = (r_state == DONE) && r_is_load;
    assign mem_fault = (r_state == ERR);
    assign stall     = ~reset & (((r_state == IDLE) & w_req_in) | (r_state == BUSY));

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl with hand-computed expectations.
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        rd_valid;
    logic        stall;
    logic        mem_fault;
    logic        mem_req;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_tests;
    int n_fail;

    int          t_stall, t_rise, t_valid, t_fault;
    logic        t_err_stall, t_err_req, t_we;
    logic [31:0] t_rd, t_wdata;
    logic [3:0]  t_be;
    logic [8:0]  t_addr;

    lsu_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Funct3    (Funct3),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .rd_valid  (rd_valid),
        .stall     (stall),
        .mem_fault (mem_fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one instruction from IDLE, answer mem_req after 'waits' BUSY
    // cycles, and keep the request inputs held through DONE/ERR.
    task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input int waits, input logic [31:0] rdata);
        int   busy;
        bit   done;
        logic prev;
        t_stall = 0; t_rise = 0; t_valid = 0; t_fault = 0;
        t_err_stall = 1'b1; t_err_req = 1'b1; t_we = 1'bx;
        t_rd = '0; t_wdata = '0; t_be = '0; t_addr = '0;
        MemRead = ld; MemWrite = st; Funct3 = f3; addr = a; wd = d;
        mem_rdata = rdata; mem_ack = 1'b0;
        busy = 0; done = 1'b0; prev = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            if (stall) t_stall++;
            if (mem_req && !prev) begin
                t_rise++;
                t_be = mem_be; t_addr = mem_addr; t_wdata = mem_wdata; t_we = mem_we;
            end
            if (rd_valid) begin
                t_valid++;
                t_rd = rd;
            end
            if (mem_fault) begin
                t_fault++;
                t_err_stall = stall;
                t_err_req = mem_req;
                done = 1'b1;
            end
            if (prev && !mem_req) done = 1'b1;
            if (mem_req) begin
                mem_ack = (busy == waits);
                busy++;
            end else begin
                mem_ack = 1'b0;
            end
            prev = mem_req;
            next_cycle();
        end
        mem_ack = 1'b0;
        if (!done) check("op_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycle();
        MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
        next_cycle();
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
        addr = 32'h10; wd = '0; mem_ack = 1'b0; mem_rdata = '0;

        // Reset state, with a request present to confirm stall is masked.
        next_cycle();
        next_cycle();
        #1;
        check("rst_stall",   {31'd0, stall},     32'd0);
        check("rst_req",     {31'd0, mem_req},   32'd0);
        check("rst_we",      {31'd0, mem_we},    32'd0);
        check("rst_valid",   {31'd0, rd_valid},  32'd0);
        check("rst_fault",   {31'd0, mem_fault}, 32'd0);
        check("rst_be",      {28'd0, mem_be},    32'd0);
        check("rst_addr",    {23'd0, mem_addr},  32'd0);
        check("rst_wdata",   mem_wdata,          32'd0);
        check("rst_rd",      rd,                 32'd0);
        MemRead = 1'b0;
        reset = 1'b0;
        next_cycle();

        // SW with two wait cycles.
        run_op(1'b0, 1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 2, 32'h0);
        check("sw_addr",  {23'd0, t_addr}, 32'h010);
        check("sw_be",    {28'd0, t_be},   32'hF);
        check("sw_wdata", t_wdata,         32'hDEADBEEF);
        check("sw_we",    {31'd0, t_we},   32'd1);
        check("sw_stall", t_stall,         32'd4);
        check("sw_valid", t_valid,         32'd0);
        check("sw_reqs",  t_rise,          32'd1);
        idle_cycle();

        // SB to the top byte lane.
        run_op(1'b0, 1'b1, 3'b000, 32'h013, 32'h000000A5, 0, 32'h0);
        check("sb_addr",  {23'd0, t_addr}, 32'h010);
        check("sb_be",    {28'd0, t_be},   32'h8);
        check("sb_wdata", t_wdata,         32'hA5A5A5A5);
        idle_cycle();

        // LB and LBU from lane 2.
        run_op(1'b1, 1'b0, 3'b000, 32'h022, 32'h0, 0, 32'h12F45678);
        check("lb_rd",    t_rd,            32'hFFFFFFF4);
        check("lb_valid", t_valid,         32'd1);
        check("lb_stall", t_stall,         32'd2);
        check("lb_we",    {31'd0, t_we},   32'd0);
        check("lb_be",    {28'd0, t_be},   32'hF);
        check("lb_addr",  {23'd0, t_addr}, 32'h020);
        idle_cycle();
        run_op(1'b1, 1'b0, 3'b100, 32'h022, 32'h0, 0, 32'h12F45678);
        check("lbu_rd",   t_rd,            32'h000000F4);
        idle_cycle();

        // LHU upper half; then misaligned LH faults and rd holds.
        run_op(1'b1, 1'b0, 3'b101, 32'h032, 32'h0, 0, 32'h80017FFF);
        check("lhu_rd",   t_rd,            32'h00008001);
        idle_cycle();
        run_op(1'b1, 1'b0, 3'b001, 32'h031, 32'h0, 0, 32'h0);
        check("lh_fault",     t_fault,                32'd1);
        check("lh_reqs",      t_rise,                 32'd0);
        check("lh_err_stall", {31'd0, t_err_stall},   32'd0);
        check("lh_err_req",   {31'd0, t_err_req},     32'd0);
        check("lh_valid",     t_valid,                32'd0);
        check("lh_rd_hold",   rd,                     32'h00008001);
        idle_cycle();

        // mem_ack outside BUSY is ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        next_cycle();
        #1;
        check("stray_ack_rd",    rd,                32'h00008001);
        check("stray_ack_valid", {31'd0, rd_valid}, 32'd0);
        check("stray_ack_req",   {31'd0, mem_req},  32'd0);
        idle_cycle();

        // SH to the upper half.
        run_op(1'b0, 1'b1, 3'b001, 32'h052, 32'h1234BEEF, 1, 32'h0);
        check("sh_be",    {28'd0, t_be},   32'hC);
        check("sh_wdata", t_wdata,         32'hBEEFBEEF);
        check("sh_addr",  {23'd0, t_addr}, 32'h050);
        idle_cycle();

        // Reset while BUSY abandons the access.
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 32'h040; mem_ack = 1'b0;
        next_cycle();
        #1;
        check("rb_busy_req", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; MemRead = 1'b0;
        next_cycle();
        #1;
        check("rb_req",   {31'd0, mem_req},  32'd0);
        check("rb_stall", {31'd0, stall},    32'd0);
        check("rb_valid", {31'd0, rd_valid}, 32'd0);
        check("rb_rd",    rd,                32'd0);
        reset = 1'b0;
        next_cycle();
        #1;
        check("rb_idle_req",   {31'd0, mem_req},  32'd0);
        check("rb_idle_valid", {31'd0, rd_valid}, 32'd0);
        next_cycle();
        run_op(1'b1, 1'b0, 3'b010, 32'h044, 32'h0, 1, 32'hCAFEF00D);
        check("lw_after_rst_rd",   t_rd,    32'hCAFEF00D);
        check("lw_after_rst_stall", t_stall, 32'd3);
        idle_cycle();

        // MemRead wins when both are set.
        run_op(1'b1, 1'b1, 3'b010, 32'h060, 32'h99999999, 0, 32'h0BADF00D);
        check("both_we", {31'd0, t_we}, 32'd0);
        check("both_rd", t_rd,          32'h0BADF00D);

        // Requests held through DONE, then a new LW straight from IDLE.
        run_op(1'b1, 1'b1, 3'b010, 32'h050, 32'h0, 0, 32'h11223344);
        check("held1_reqs", t_rise, 32'd1);
        check("held1_rd",   t_rd,   32'h11223344);
        run_op(1'b1, 1'b0, 3'b010, 32'h054, 32'h0, 0, 32'h55667788);
        check("held2_reqs", t_rise, 32'd1);
        check("held2_rd",   t_rd,   32'h55667788);
        check("held2_addr", {23'd0, t_addr}, 32'h054);
        idle_cycle();

        // Illegal store Funct3.
        run_op(1'b0, 1'b1, 3'b011, 32'h070, 32'h0, 0, 32'h0);
        check("s011_fault", t_fault, 32'd1);
        check("s011_reqs",  t_rise,  32'd0);
        check("s011_rd",    rd,      32'h55667788);
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store initiator for the MEM stage of the RISC-V pipeline, the requester side of the data-memory interface. It takes a load or store from the pipeline, checks alignment, and builds the word address, byte enables and lane-replicated store data. It issues the access with a req/ack handshake, stalling the pipeline until the access completes. For loads it extracts, sign-extends or zero-extends the addressed byte, halfword or word and returns it.

## Interface
- DM_ADDRESS, 9, data-memory byte-address width (LSBs of ALU result used)
- DATA_W, 32, data width (fixed at 32 for lane logic)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- Funct3  in  3  instruction bits 14:12
- addr  in  DATA_W  ALU result (byte address)
- wd  in  DATA_W  store data (rs2)
- rd  out  DATA_W  load result
- rd_valid  out  1  rd valid (one-cycle pulse)
- stall  out  1  hold pipeline (combinational)
- mem_fault  out  1  misaligned or illegal Funct3 (one-cycle pulse)
- mem_req  out  1  access request to data memory
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DM_ADDRESS  word-aligned address, bits 1:0 = 0
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_W  lane-aligned store data
- mem_ack  in  1  memory completion; rdata valid in same cycle
- mem_rdata  in  DATA_W  read word

## Operation
- FSM states: IDLE, BUSY, DONE, ERR. Reset → IDLE.
- IDLE:
  - No request: stay in IDLE.
  - MemRead or MemWrite: MemRead wins if both are set. Latch op, Funct3, offset addr[1:0], mem_addr, mem_be and mem_wdata.
  - Legal access → BUSY. Fault → ERR.
- Legal Funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other value is a fault.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0; B is always aligned.
- Store lanes (off = addr[1:0]):
  - SB: be = 4'b0001<<off, wdata = {4{wd[7:0]}}
  - SH: be = 4'b0011<<off, wdata = {2{wd[15:0]}}
  - SW: be = 4'b1111, wdata = wd
- Loads: mem_be = 4'b1111, mem_we = 0.
- BUSY: mem_req = 1. Address, be, we and wdata are held stable.
  - mem_ack = 1 at an edge: for loads, capture the extracted result into rd. Go to DONE.
- Load extraction: shift mem_rdata right by 8*off. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- DONE: rd_valid = 1 for loads only (0 for stores). → IDLE unconditionally.
  - MemRead/MemWrite still asserted in DONE belong to the completed instruction and never re-trigger an access.
- ERR: mem_fault = 1, rd_valid = 0, no mem_req. → IDLE.
- rd holds its last value until the next load completes.
- mem_ack outside BUSY is ignored.

## Timing
- stall = 1 in IDLE when (MemRead | MemWrite), and in BUSY. stall = 0 in DONE, ERR, and whenever reset is high.
- Minimum access: IDLE, BUSY (ack), DONE = 3 cycles with stall high for 2. Each extra wait cycle without ack adds one BUSY cycle.
- The pipeline advances on the DONE/ERR edge. A new access is accepted in the following IDLE cycle, so back-to-back accesses take 3 cycles each.
- mem_req rises the cycle after the request is seen in IDLE. It falls the cycle after the ack edge.
- Reset values: state IDLE; mem_req, mem_we, rd_valid, mem_fault = 0; mem_be = 0; mem_addr, mem_wdata, rd = 0.
- Reset in BUSY: an abandoned access is permitted. mem_req is 0 in the first cycle after the reset edge, and no rd_valid is issued.

## Test plan
- SW addr=0x010, wd=0xDEADBEEF, ack after 2 wait cycles → mem_addr=0x010, be=1111, wdata=0xDEADBEEF, mem_we=1; stall high 4 cycles; rd_valid stays 0.
- SB addr=0x013, wd=0x000000A5 → mem_addr=0x010, be=1000, wdata=0xA5A5A5A5.
- LB addr=0x022, mem_rdata=0x12F45678, ack in first BUSY cycle → rd=0xFFFFFFF4, rd_valid pulse in DONE; same stimulus with LBU → rd=0x000000F4.
- LHU addr=0x032, mem_rdata=0x8001_7FFF → rd=0x00008001; LH addr=0x031 → mem_fault pulse, no mem_req, stall low in ERR cycle.
- Reset asserted during BUSY (no ack) → mem_req=0, stall=0, state IDLE next cycle; a following LW completes normally.
- MemRead and MemWrite held through DONE, then a new LW in IDLE → exactly one request per instruction; Funct3=011 store → mem_fault.
